fnn_weight_loader: RTL and testbench
====================================

FNN_WEIGHT_LOADER -- requirements
Module: fnn_weight_loader

Interface
REQ-001 SHALL have parameter NEURONS, default 4, giving neurons per layer.
REQ-002 SHALL have parameter LAYERS, default 4, giving the layer count.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a new load session.
REQ-006 SHALL have port abort, input, 1 bit: discard the session in progress.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a byte.
REQ-008 SHALL have port in_data, input, 8 bits: weight, bias or checksum byte.
REQ-009 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-010 SHALL have port weights_flat, output, LAYERS*NEURONS*NEURONS*8 bits: committed weights; w[l][i][j] at bits 8*((l*NEURONS+i)*NEURONS+j) +: 8.
REQ-011 SHALL have port biases_flat, output, LAYERS*NEURONS*8 bits: committed biases; b[l][i] at bits 8*(l*NEURONS+i) +: 8.
REQ-012 SHALL have port load_busy, output, 1 bit: a session is in progress.
REQ-013 SHALL have port load_done, output, 1 bit: the last session committed.
REQ-014 SHALL have port load_err, output, 1 bit: the last session failed its checksum.

Function
REQ-015 SHALL use FSM states IDLE, LOAD, CHECK, COMMIT and DONE.
REQ-016 SHALL accept a byte only on a rising edge where in_valid=1 and in_ready=1.
REQ-017 SHALL drive in_ready=1 only in LOAD and CHECK, combinationally from the state.
REQ-018 SHALL take the stream order, per layer l=0..LAYERS-1: NEURONS*NEURONS weights row-major (i outer, j inner), then NEURONS biases i=0..NEURONS-1.
REQ-019 SHALL write accepted bytes into a shadow bank; weights_flat and biases_flat SHALL stay unchanged until COMMIT.
REQ-020 SHALL use a byte counter of at least 7 bits, cleared on entry to LOAD and incremented per accepted byte; total bytes = LAYERS*NEURONS*(NEURONS+1) (80 by default).
REQ-021 SHALL move IDLE/DONE -> LOAD when start=1, clearing load_done and load_err and setting load_busy.
REQ-022 SHALL ignore start while in LOAD, CHECK or COMMIT.
REQ-023 SHALL leave LOAD on the edge accepting the final byte, going to COMMIT (or CHECK, see REQ-030).
REQ-024 In COMMIT, SHALL copy the shadow bank to the outputs in one cycle, set load_done=1, clear load_busy and enter DONE; outputs update one edge after the final byte.
REQ-025 SHALL return from any state to IDLE on abort=1 without committing; load_busy=0, load_done unchanged.
REQ-026 SHALL give abort priority when abort and start are both 1.
REQ-027 SHALL treat in_valid=0 stalls in LOAD as no-ops, with no timeout.

Reset
REQ-028 SHALL, on reset, enter IDLE and clear the counter, shadow bank, weights_flat, biases_flat, load_busy, load_done and load_err.
REQ-029 SHALL, on reset mid-session, discard all partial data; the next session restarts at byte 0.

Configuration
REQ-030 With FNN_WLOAD_CHECKSUM_EN defined, SHALL go to CHECK after the final data byte and accept one checksum byte, the mod-256 sum of all data bytes; on a match go to COMMIT; on a mismatch set load_err=1, clear load_busy, return to IDLE and commit nothing.
REQ-031 Without FNN_WLOAD_CHECKSUM_EN, SHALL have no CHECK state; load_err SHALL be tied to 0.

Verification
REQ-032 Reset, start, 80 bytes 0x00..0x4F with in_valid held -> weights_flat[7:0]=0x00, biases_flat[7:0]=0x10, biases_flat[127:120]=0x4F, load_done=1 one edge after the 80th byte.
REQ-033 Same stream with in_valid toggled every other cycle -> identical outputs; in_ready stays 1 throughout LOAD.
REQ-034 Abort after 40 bytes -> previous weights_flat/biases_flat unchanged, load_busy=0; a fresh start plus 80 bytes commits normally.
REQ-035 Reset asserted after byte 10 -> all outputs 0, in_ready=0; start stays ignored until reset is released.
REQ-036 With FNN_WLOAD_CHECKSUM_EN: 80 bytes all 0x01, checksum 0x50 -> commit, load_done=1; checksum 0x51 -> load_err=1, outputs unchanged.
REQ-037 Start pulsed mid-LOAD at byte 20 -> ignored; the byte counter continues and the session completes at 80 bytes.

Source files
------------

// File: rtl/fnn_weight_loader.sv
// Streams per-layer weights and biases into a shadow bank, then commits them to the outputs in one cycle.
// Optional trailing checksum byte when FNN_WLOAD_CHECKSUM_EN is defined.
module fnn_weight_loader #(
    parameter int unsigned NEURONS = 4,
    parameter int unsigned LAYERS  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 in_valid,
    input  logic [7:0]                           in_data,
    output logic                                 in_ready,
    output logic [LAYERS*NEURONS*NEURONS*8-1:0]  weights_flat,
    output logic [LAYERS*NEURONS*8-1:0]          biases_flat,
    output logic                                 load_busy,
    output logic                                 load_done,
    output logic                                 load_err
);

    localparam int unsigned NN        = NEURONS * NEURONS;
    localparam int unsigned PER_LAYER = NN + NEURONS;
    localparam int unsigned TOTAL     = LAYERS * PER_LAYER;
    localparam int unsigned NW        = LAYERS * NN;
    localparam int unsigned NB        = LAYERS * NEURONS;
    localparam int unsigned CW_MIN    = $clog2(TOTAL + 1);
    localparam int unsigned CW        = (CW_MIN > 7) ? CW_MIN : 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef FNN_WLOAD_CHECKSUM_EN
        CHECK,
`endif
        COMMIT,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    lyr;
    logic [CW-1:0]    pos;
    logic [NW*8-1:0]  shadow_w;
    logic [NB*8-1:0]  shadow_b;
    logic [CW-1:0]    w_idx;
    logic [CW-1:0]    b_idx;
    logic             is_bias;
    logic             accept;
    logic             last_byte;

`ifdef FNN_WLOAD_CHECKSUM_EN
    logic [7:0]       sum;
    logic             err_q;
    assign in_ready = (state == LOAD) || (state == CHECK);
    assign load_err = err_q;
`else
    assign in_ready = (state == LOAD);
    assign load_err = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign last_byte = (cnt == CW'(TOTAL - 1));

    // Map the position inside the current layer onto a weight or bias slot.
    always_comb begin
        is_bias = (pos >= CW'(NN));
        w_idx   = lyr * CW'(NN) + pos;
        b_idx   = lyr * CW'(NEURONS) + (pos - CW'(NN));
    end

    // Shadow bank: written only while streaming data bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_w <= '0;
            shadow_b <= '0;
        end else if (accept && (state == LOAD)) begin
            for (int unsigned k = 0; k < NW; k++) begin
                if (!is_bias && (w_idx == CW'(k))) shadow_w[8*k +: 8] <= in_data;
            end
            for (int unsigned k = 0; k < NB; k++) begin
                if (is_bias && (b_idx == CW'(k))) shadow_b[8*k +: 8] <= in_data;
            end
        end
    end

    // Session control; abort wins over everything, including start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lyr          <= '0;
            pos          <= '0;
            weights_flat <= '0;
            biases_flat  <= '0;
            load_busy    <= 1'b0;
            load_done    <= 1'b0;
`ifdef FNN_WLOAD_CHECKSUM_EN
            sum          <= '0;
            err_q        <= 1'b0;
`endif
        end else if (abort) begin
            state     <= IDLE;
            load_busy <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        lyr       <= '0;
                        pos       <= '0;
                        load_busy <= 1'b1;
                        load_done <= 1'b0;
`ifdef FNN_WLOAD_CHECKSUM_EN
                        sum       <= '0;
                        err_q     <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
                        cnt <= cnt + CW'(1);
                        if (pos == CW'(PER_LAYER - 1)) begin
                            pos <= '0;
                            lyr <= lyr + CW'(1);
                        end else begin
                            pos <= pos + CW'(1);
                        end
`ifdef FNN_WLOAD_CHECKSUM_EN
                        sum <= sum + in_data;
                        if (last_byte) state <= CHECK;
`else
                        if (last_byte) state <= COMMIT;
`endif
                    end
                end
`ifdef FNN_WLOAD_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (in_data == sum) begin
                            state <= COMMIT;
                        end else begin
                            err_q     <= 1'b1;
                            load_busy <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
`endif
                COMMIT: begin
                    weights_flat <= shadow_w;
                    biases_flat  <= shadow_b;
                    load_done    <= 1'b1;
                    load_busy    <= 1'b0;
                    state        <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fnn_weight_loader.sv
// Scoreboard bench for fnn_weight_loader: expected banks queued as streams are driven, checked at commit.
module tb_fnn_weight_loader;

    localparam int unsigned NEURONS   = 4;
    localparam int unsigned LAYERS    = 4;
    localparam int unsigned NN        = NEURONS * NEURONS;
    localparam int unsigned PER_LAYER = NN + NEURONS;
    localparam int unsigned TOTAL     = LAYERS * PER_LAYER;
    localparam int unsigned WW        = LAYERS * NN * 8;
    localparam int unsigned BW        = LAYERS * NEURONS * 8;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [WW-1:0] weights_flat;
    logic [BW-1:0] biases_flat;
    logic          load_busy;
    logic          load_done;
    logic          load_err;

    typedef struct packed {
        logic [WW-1:0] w;
        logic [BW-1:0] b;
    } exp_t;

    exp_t          sb_q[$];
    logic [WW-1:0] sh_w;
    logic [BW-1:0] sh_b;
    logic [WW-1:0] com_w;
    logic [BW-1:0] com_b;
    logic [7:0]    sum;
    logic          ready_drop;
    int            total;
    int            bad;

    fnn_weight_loader #(.NEURONS(NEURONS), .LAYERS(LAYERS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .weights_flat (weights_flat),
        .biases_flat  (biases_flat),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [7:0] gen(input int mode, input int k);
        case (mode)
            0:       gen = 8'(k);
            9:       gen = 8'h01;
            default: gen = 8'(k * (2 * mode + 1) + 37 * mode);
        endcase
    endfunction

    task automatic model_put(input int k, input logic [7:0] b);
        int l;
        int p;
        l = k / PER_LAYER;
        p = k % PER_LAYER;
        if (p < NN) sh_w[8*(l*NN+p) +: 8] = b;
        else        sh_b[8*(l*NEURONS+p-NN) +: 8] = b;
        sum = sum + b;
    endtask

    task automatic begin_session();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on_start", load_busy, 1'b1);
        check("done_clr_on_start", load_done, 1'b0);
        check("err_clr_on_start", load_err, 1'b0);
        check("ready_on_start", in_ready, 1'b1);
        sum        = 8'h00;
        ready_drop = 1'b0;
    endtask

    task automatic send_bytes(input int mode, input int from, input int to, input bit toggle);
        for (int k = from; k < to; k++) begin
            if (toggle) begin
                in_valid = 1'b0;
                @(negedge clk);
                if (!in_ready) ready_drop = 1'b1;
            end
            in_valid = 1'b1;
            in_data  = gen(mode, k);
            if (!in_ready) ready_drop = 1'b1;
            model_put(k, in_data);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic finish_session();
        exp_t e;
        sb_q.push_back({sh_w, sh_b});
`ifdef FNN_WLOAD_CHECKSUM_EN
        in_valid = 1'b1;
        in_data  = sum;
        @(negedge clk);
        in_valid = 1'b0;
`endif
        check("ready_held_in_load", ready_drop, 1'b0);
        check("done_before_commit", load_done, 1'b0);
        check("hold_w_before_commit", weights_flat, com_w);
        check("hold_b_before_commit", biases_flat, com_b);
        @(negedge clk);
        check("done_after_commit", load_done, 1'b1);
        check("busy_after_commit", load_busy, 1'b0);
        check("err_after_commit", load_err, 1'b0);
        check("ready_after_commit", in_ready, 1'b0);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1'b0, 1'b1);
        end else begin
            e = sb_q.pop_front();
            check("weights", weights_flat, e.w);
            check("biases", biases_flat, e.b);
            com_w = e.w;
            com_b = e.b;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        sh_w     = '0;
        sh_b     = '0;
        com_w    = '0;
        com_b    = '0;
        sum      = 8'h00;
        ready_drop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_weights", weights_flat, '0);
        check("rst_biases", biases_flat, '0);
        check("rst_busy", load_busy, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_err", load_err, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Continuous ramp 0x00..0x4F.
        begin_session();
        send_bytes(0, 0, TOTAL, 1'b0);
        finish_session();
        check("w000", weights_flat[7:0], 8'h00);
        check("b00", biases_flat[7:0], 8'h10);
        check("b33", biases_flat[127:120], 8'h4F);

        // Same ramp with in_valid toggling every other cycle.
        begin_session();
        send_bytes(0, 0, TOTAL, 1'b1);
        finish_session();

        // Abort from DONE keeps load_done.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done_kept", load_done, 1'b1);
        check("abort_done_busy", load_busy, 1'b0);

        // Abort after 40 bytes, then simultaneous abort+start in IDLE.
        begin_session();
        send_bytes(2, 0, 40, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", load_busy, 1'b0);
        check("abort_ready", in_ready, 1'b0);
        check("abort_w_hold", weights_flat, com_w);
        check("abort_b_hold", biases_flat, com_b);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_over_start", load_busy, 1'b0);
        begin_session();
        send_bytes(2, 0, TOTAL, 1'b0);
        finish_session();

        // Start pulsed together with byte 20 must be ignored.
        begin_session();
        send_bytes(3, 0, 20, 1'b0);
        start = 1'b1;
        send_bytes(3, 20, 21, 1'b0);
        start = 1'b0;
        check("mid_start_busy", load_busy, 1'b1);
        send_bytes(3, 21, TOTAL, 1'b0);
        finish_session();

        // Reset after byte 10; start ignored while reset held.
        begin_session();
        send_bytes(4, 0, 10, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_weights", weights_flat, '0);
        check("midrst_biases", biases_flat, '0);
        check("midrst_done", load_done, 1'b0);
        check("midrst_ready", in_ready, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midrst_start_ignored", load_busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("postrst_ready", in_ready, 1'b0);
        check("postrst_busy", load_busy, 1'b0);
        com_w = '0;
        com_b = '0;
        begin_session();
        send_bytes(5, 0, TOTAL, 1'b1);
        finish_session();

`ifdef FNN_WLOAD_CHECKSUM_EN
        // All-ones stream with the correct checksum 0x50 commits.
        begin_session();
        send_bytes(9, 0, TOTAL, 1'b0);
        check("ck_sum_model", sum, 8'h50);
        finish_session();

        // Same stream with checksum 0x51 fails.
        begin_session();
        send_bytes(9, 0, TOTAL, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h51;
        @(negedge clk);
        in_valid = 1'b0;
        check("ck_bad_err", load_err, 1'b1);
        check("ck_bad_busy", load_busy, 1'b0);
        check("ck_bad_done", load_done, 1'b0);
        check("ck_bad_ready", in_ready, 1'b0);
        @(negedge clk);
        check("ck_bad_w_hold", weights_flat, com_w);
        check("ck_bad_b_hold", biases_flat, com_b);

        // Different data with a wrong checksum must not reach the outputs.
        begin_session();
        send_bytes(7, 0, TOTAL, 1'b0);
        in_valid = 1'b1;
        in_data  = sum + 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("ck_bad2_err", load_err, 1'b1);
        check("ck_bad2_w_hold", weights_flat, com_w);
        check("ck_bad2_b_hold", biases_flat, com_b);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
